// File: rtl/led_fade_pwm_if.sv
// Pattern handshake between the LED pattern generator and the fade stage.
// No logic, so it adds no latency.
// The pattern is held by the master while in_valid=1 and in_ready=0.
interface led_fade_pwm_if #(
  parameter int CHANNELS = 5
);
  logic [CHANNELS-1:0] in_pattern;
  logic                in_valid;
  logic                in_ready;

  modport master (output in_pattern, output in_valid, input in_ready);
  modport slave  (input in_pattern, input in_valid, output in_ready);
endinterface

// File: rtl/led_fade_pwm.sv
// Fades each LED channel linearly toward an on/off target and drives the pads with PWM.
// led is registered from (level > pwm_cnt), one cycle behind; a full ramp takes MAX*2^STEP_LOG2 cycles.
// in_ready drops for the whole ramp; a pattern offered meanwhile is taken on the first idle cycle.
module led_fade_pwm #(
  parameter int CHANNELS  = 5,
  parameter int PWM_BITS  = 8,
  parameter int STEP_LOG2 = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  led_fade_pwm_if.slave       in_if,
  output logic [CHANNELS-1:0] led,
  output logic                busy
);

  typedef logic [PWM_BITS-1:0]  level_t;
  typedef logic [STEP_LOG2-1:0] presc_t;

  localparam level_t LVL_MAX   = {PWM_BITS{1'b1}};
  localparam level_t LVL_ZERO  = {PWM_BITS{1'b0}};
  localparam level_t LVL_ONE   = {{(PWM_BITS-1){1'b0}}, 1'b1};
  localparam presc_t PRESC_ONE = {{(STEP_LOG2-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RAMP = 1'b1
  } state_t;

  state_t              state_q, state_d;
  presc_t              presc_q, presc_d;
  level_t              pwm_cnt_q, pwm_cnt_d;
  logic [CHANNELS-1:0] target_q, target_d;
  level_t              level_q [CHANNELS];
  level_t              level_d [CHANNELS];
  logic [CHANNELS-1:0] led_q, led_d;

  logic tick;
  logic settled;
  logic ready;
  logic accept;

  // Free-running prescaler and PWM counter; tick marks the last prescaler cycle.
  always_comb begin
    presc_d   = presc_q + PRESC_ONE;
    pwm_cnt_d = pwm_cnt_q + LVL_ONE;
    tick      = &presc_q;
  end

  // Every channel sits at the rail its target bit asks for.
  always_comb begin
    settled = 1'b1;
    for (int i = 0; i < CHANNELS; i++) begin
      if (level_q[i] != (target_q[i] ? LVL_MAX : LVL_ZERO)) begin
        settled = 1'b0;
      end
    end
  end

  // Capture a new target on a handshake; the level update below still sees the old target this cycle.
  always_comb begin
    accept   = in_if.in_valid & ready;
    target_d = accept ? in_if.in_pattern : target_q;
  end

  // One saturating step per channel on each tick, toward the current target.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      level_d[i] = level_q[i];
      if (tick) begin
        if (target_q[i] && (level_q[i] != LVL_MAX)) begin
          level_d[i] = level_q[i] + LVL_ONE;
        end else if (!target_q[i] && (level_q[i] != LVL_ZERO)) begin
          level_d[i] = level_q[i] - LVL_ONE;
        end
      end
    end
  end

  // PWM compare, registered so the pads see a clean edge.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      led_d[i] = (level_q[i] > pwm_cnt_q);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a differing pattern starts a ramp, which ends once every level is settled.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (in_if.in_pattern != target_q)) begin
          state_d = ST_RAMP;
        end
      end
      ST_RAMP: begin
        if (settled) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: ready only while idle.
  always_comb begin
    ready = (state_q == ST_IDLE);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      target_q  <= '0;
      led_q     <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        level_q[i] <= '0;
      end
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      target_q  <= target_d;
      led_q     <= led_d;
      for (int i = 0; i < CHANNELS; i++) begin
        level_q[i] <= level_d[i];
      end
    end
  end

  assign in_if.in_ready = ready;
  assign busy           = ~ready;
  assign led            = led_q;

endmodule
